t_state_sequencer: RTL and testbench
====================================

Name: t_state_sequencer

Overview:
Parametrised T-state sequencer for the control unit. It generalises the fixed one-hot ring counter in four ways: configurable maximum depth, a per-instruction cycle length, early end-of-cycle, and halt/freeze. It also provides binary index, first/last flags and a completed-cycle counter. It drives the control-word decoder and replaces the fixed-length ring in the SAP datapath.

Parameters:
MAX_STATES, 6, maximum number of T-states per instruction cycle (legal range 2..16)
CNT_WIDTH, 8, width of completed-cycle counter
LW, $clog2(MAX_STATES+1), derived: width of len and t_idx (not overridden)

Ports:
CLK  input  1  system clock; all state updates on falling edge, matching the existing control sequencer
CLR_bar  input  1  synchronous active-low reset, sampled on the falling edge of CLK
HLT  input  1  halt; when 1, all state frozen
NXT  input  1  early end-of-cycle request; next state is T1
len  input  LW  T-states in the upcoming cycle; latched at each entry to T1
state  output  MAX_STATES  one-hot T-state; bit k = T(k+1); all zeros = idle
t_idx  output  LW  binary T index: 0 = idle, 1..MAX_STATES
cyc_start  output  1  1 while in T1
cyc_last  output  1  1 while in the final T-state of the latched length
cyc_cnt  output  CNT_WIDTH  count of completed instruction cycles, wraps modulo 2^CNT_WIDTH

Behaviour:
- Timing: all registers update only on the falling edge of CLK. Reset is synchronous: no asynchronous path from CLR_bar.
- Reset (CLR_bar=0 at a falling edge): state=0, t_idx=0, cyc_start=0, cyc_last=0, cyc_cnt=0, latched length=MAX_STATES. CLR_bar has priority over every other input. Reset mid-cycle aborts the cycle without counting it.
- Priority per edge: CLR_bar > HLT > idle exit > NXT > normal advance.
- Idle (state=0), HLT=0: go to T1 and latch len. cyc_cnt unchanged. NXT is ignored in idle.
- Idle, HLT=1: remain idle.
- Length normalisation when latching: len=0 -> MAX_STATES; len>MAX_STATES -> MAX_STATES; otherwise len.
- Active state Tk, HLT=1: no register changes, including the latched length and cyc_cnt.
- Active state Tk, NXT=1: go to T1, latch len, cyc_cnt+1. Applies even when Tk is T1.
- Active state Tk, k < latched length: go to T(k+1).
- Active state Tk, k = latched length: wrap to T1, latch new len, cyc_cnt+1.
- Latched length 1: T1 repeats every edge and cyc_cnt increments every edge.
- Outputs are registered or derived purely from registers; no combinational path from any input to any output.
- t_idx = index of the set bit of state.
- cyc_start = state[0].
- cyc_last = active state index equals latched length.
- state is always exactly one-hot or all-zero. An illegal multi-hot encoding cannot arise except through an X or upset. On such an encoding, the next non-halted edge must force T1 (self-recovery), not propagate the corruption.
- cyc_cnt wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- A change on len while not at a T1 entry has no effect until the next T1 entry.

Test Plan:
1. Reset and free-run, MAX_STATES=6, len=0: hold CLR_bar=0 for 2 edges, then release.
   -> state 000000, then 000001, 000010, …, 100000, back to 000001.
   -> cyc_last=1 only at 100000; cyc_cnt=1 after the first wrap.
2. Short cycle: len=3 latched at T1.
   -> T1, T2, T3 (cyc_last=1), T1 repeating; cyc_cnt +1 every 3 edges.
   -> Change len to 5 while in T2: takes effect only from the following T1.
3. Early end: len=6; pulse NXT during T4.
   -> next edge T1; cyc_cnt +1; T5 and T6 never appear in that cycle.
4. Halt: HLT=1 during T3 for 4 edges.
   -> state, t_idx and cyc_cnt all unchanged; resumes at T4 on the first edge after HLT=0.
   -> HLT and NXT together: halt wins.
5. Boundaries:
   -> len=1: cyc_start=1 and cyc_last=1 continuously, cyc_cnt +1 per edge.
   -> len=7 with MAX_STATES=6: behaves as 6.
   -> CNT_WIDTH=2: cyc_cnt sequence 3 -> 0.
6. Reset mid-cycle and sync check: CLR_bar=0 pulse during T5 that does not span a falling edge.
   -> no effect (synchronous reset).
   -> Pulse spanning a falling edge: idle, cyc_cnt=0, then T1 on the next edge.

Source files
------------

// File: rtl/t_state_sequencer.sv
// T-state sequencer for the control unit.
// Steps a one-hot T-state through a per-instruction cycle length that is
// latched on every entry to T1. Supports early end-of-cycle (NXT), halt
// (HLT), and reports binary index, first/last flags and a completed-cycle
// count. All registers update on the falling edge of CLK.
//
// Ports:
//   CLK        system clock (state updates on falling edge)
//   CLR_bar    synchronous active-low clear, highest priority
//   HLT        freeze all state while high
//   NXT        early end-of-cycle request, next state is T1
//   len        T-states in the upcoming cycle, latched at each T1 entry
//   state      one-hot T-state, bit k = T(k+1), zero = idle
//   t_idx      binary T index, 0 = idle
//   cyc_start  high while in T1
//   cyc_last   high while in the final T-state of the latched length
//   cyc_cnt    completed instruction cycles, wraps silently
module t_state_sequencer #(
    parameter int unsigned MAX_STATES = 6,
    parameter int unsigned CNT_WIDTH  = 8,
    localparam int unsigned LW        = $clog2(MAX_STATES + 1)
) (
    input  logic                  CLK,
    input  logic                  CLR_bar,
    input  logic                  HLT,
    input  logic                  NXT,
    input  logic [LW-1:0]         len,
    output logic [MAX_STATES-1:0] state,
    output logic [LW-1:0]         t_idx,
    output logic                  cyc_start,
    output logic                  cyc_last,
    output logic [CNT_WIDTH-1:0]  cyc_cnt
);

    localparam logic [LW-1:0]         LEN_MAX  = LW'(MAX_STATES);
    localparam logic [MAX_STATES-1:0] T1_STATE = MAX_STATES'(1);

    logic [MAX_STATES-1:0] state_q, state_d;
    logic [LW-1:0]         len_q, len_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LW-1:0]         t_idx_q, t_idx_d;
    logic                  cyc_start_q, cyc_start_d;
    logic                  cyc_last_q, cyc_last_d;

    logic [LW-1:0]         len_norm;
    logic [LW-1:0]         cur_idx;
    logic                  cur_legal;

    // Binary index of a one-hot vector (1-based, 0 when empty).
    function automatic logic [LW-1:0] onehot_idx(input logic [MAX_STATES-1:0] s);
        logic [LW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_STATES; i++) begin
            if (s[i]) begin
                idx = idx | LW'(i + 1);
            end
        end
        return idx;
    endfunction

    // Decode of the current state and normalisation of the requested length.
    always_comb begin
        len_norm = len;
        if (len == '0 || len > LEN_MAX) begin
            len_norm = LEN_MAX;
        end
        // Zero or single bit set; anything else is a corrupted encoding.
        cur_legal = ((state_q & (state_q - T1_STATE)) == '0);
        cur_idx   = onehot_idx(state_q);
    end

    // State register with synchronous clear.
    always_ff @(negedge CLK) begin
        if (!CLR_bar) begin
            state_q     <= '0;
            len_q       <= LEN_MAX;
            cnt_q       <= '0;
            t_idx_q     <= '0;
            cyc_start_q <= 1'b0;
            cyc_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            t_idx_q     <= t_idx_d;
            cyc_start_q <= cyc_start_d;
            cyc_last_q  <= cyc_last_d;
        end
    end

    // Next-state logic: halt > idle exit / recovery > early end > advance.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        if (!HLT) begin
            if (state_q == '0 || !cur_legal) begin
                // Idle exit, or recovery from a multi-hot upset: restart at T1.
                state_d = T1_STATE;
                len_d   = len_norm;
            end else if (NXT || cur_idx >= len_q) begin
                state_d = T1_STATE;
                len_d   = len_norm;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
            end else begin
                state_d = {state_q[MAX_STATES-2:0], 1'b0};
            end
        end
    end

    // Output logic: derived from the next state so the flags are registered.
    always_comb begin
        t_idx_d     = onehot_idx(state_d);
        cyc_start_d = state_d[0];
        cyc_last_d  = (state_d != '0) && (onehot_idx(state_d) == len_d);
    end

    assign state     = state_q;
    assign t_idx     = t_idx_q;
    assign cyc_start = cyc_start_q;
    assign cyc_last  = cyc_last_q;
    assign cyc_cnt   = cnt_q;

endmodule

// File: tb/tb_t_state_sequencer.sv
// Testbench for t_state_sequencer: directed scenarios with literal
// expectations followed by randomized stimulus, all checked each cycle
// against a position/length/count model of the sequencer.
module tb_t_state_sequencer;

    localparam int unsigned MAXS = 6;
    localparam int unsigned LW   = $clog2(MAXS + 1);

    logic            CLK = 1'b0;
    logic            CLR_bar = 1'b0;
    logic            HLT = 1'b0;
    logic            NXT = 1'b0;
    logic [LW-1:0]   len = '0;

    logic [MAXS-1:0] state, state2;
    logic [LW-1:0]   t_idx, t_idx2;
    logic            cyc_start, cyc_start2;
    logic            cyc_last, cyc_last2;
    logic [7:0]      cyc_cnt;
    logic [1:0]      cyc_cnt2;

    int total = 0;
    int bad   = 0;

    // Reference model: position 0 = idle, else 1..MAXS.
    bit mvalid = 1'b0;
    int mpos   = 0;
    int mlen   = MAXS;
    int mcnt   = 0;

    always #5 CLK = ~CLK;

    t_state_sequencer #(.MAX_STATES(MAXS), .CNT_WIDTH(8)) u_dut (
        .CLK(CLK), .CLR_bar(CLR_bar), .HLT(HLT), .NXT(NXT), .len(len),
        .state(state), .t_idx(t_idx), .cyc_start(cyc_start),
        .cyc_last(cyc_last), .cyc_cnt(cyc_cnt)
    );

    t_state_sequencer #(.MAX_STATES(MAXS), .CNT_WIDTH(2)) u_dut2 (
        .CLK(CLK), .CLR_bar(CLR_bar), .HLT(HLT), .NXT(NXT), .len(len),
        .state(state2), .t_idx(t_idx2), .cyc_start(cyc_start2),
        .cyc_last(cyc_last2), .cyc_cnt(cyc_cnt2)
    );

    function automatic int norm(input int l);
        return (l == 0 || l > int'(MAXS)) ? int'(MAXS) : l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model step on the same edge as the DUT.
    always @(negedge CLK) begin
        if (!CLR_bar) begin
            mvalid = 1'b1;
            mpos   = 0;
            mlen   = MAXS;
            mcnt   = 0;
        end else if (!HLT) begin
            if (mpos == 0) begin
                mpos = 1;
                mlen = norm(int'(len));
            end else if (NXT || mpos == mlen) begin
                mpos = 1;
                mlen = norm(int'(len));
                mcnt = mcnt + 1;
            end else begin
                mpos = mpos + 1;
            end
        end
    end

    // Every-cycle comparison, sampled on the rising edge.
    logic [31:0] es;
    always @(posedge CLK) begin
        if (mvalid) begin
            es = (mpos == 0) ? 32'd0 : (32'd1 << (mpos - 1));
            chk("state",      32'(state),      es);
            chk("t_idx",      32'(t_idx),      32'(mpos));
            chk("cyc_start",  32'(cyc_start),  32'(mpos == 1));
            chk("cyc_last",   32'(cyc_last),   32'(mpos != 0 && mpos == mlen));
            chk("cyc_cnt",    32'(cyc_cnt),    32'(mcnt % 256));
            chk("state2",     32'(state2),     es);
            chk("t_idx2",     32'(t_idx2),     32'(mpos));
            chk("cyc_start2", 32'(cyc_start2), 32'(mpos == 1));
            chk("cyc_last2",  32'(cyc_last2),  32'(mpos != 0 && mpos == mlen));
            chk("cyc_cnt2",   32'(cyc_cnt2),   32'(mcnt % 4));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Advance until the model reaches position p (at least one edge), bounded.
    task automatic wait_pos(input int p);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (mpos != p && n < 40);
        if (mpos != p) begin
            total++;
            bad++;
            $display("FAIL wait_pos timeout got=%0d want=%0d", mpos, p);
        end
    endtask

    int c0;

    initial begin
        // 1. Reset for two edges, then free-run at len=0 (treated as 6).
        repeat (3) tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_idx",   32'(t_idx), 32'd0);
        chk("rst_cnt",   32'(cyc_cnt), 32'd0);
        CLR_bar = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("run_state", 32'(state), 32'd1 << i);
            chk("run_last",  32'(cyc_last), 32'(i == 5));
            chk("run_cnt",   32'(cyc_cnt), 32'd0);
            tick();
        end
        chk("wrap_state", 32'(state), 32'd1);
        chk("wrap_cnt",   32'(cyc_cnt), 32'd1);

        // 2. Short cycle of 3; len change mid-cycle waits for next T1.
        len = 3'd3;
        wait_pos(1);
        c0 = mcnt;
        chk("s3_t1", 32'(state), 32'd1);
        tick();
        chk("s3_t2", 32'(state), 32'd2);
        len = 3'd5;
        tick();
        chk("s3_t3",    32'(state), 32'd4);
        chk("s3_last",  32'(cyc_last), 32'd1);
        chk("s3_idx",   32'(t_idx), 32'd3);
        tick();
        chk("s5_t1",    32'(state), 32'd1);
        chk("s5_cnt",   32'(cyc_cnt), 32'((c0 + 1) % 256));
        tick();
        tick();
        chk("s5_t3",    32'(state), 32'd4);
        chk("s5_nlast", 32'(cyc_last), 32'd0);
        tick();
        tick();
        chk("s5_t5",    32'(state), 32'd16);
        chk("s5_last",  32'(cyc_last), 32'd1);

        // 3. Early end at T4.
        len = 3'd6;
        tick();
        repeat (3) tick();
        chk("nx_t4", 32'(state), 32'd8);
        c0 = mcnt;
        NXT = 1'b1;
        tick();
        NXT = 1'b0;
        chk("nx_t1",  32'(state), 32'd1);
        chk("nx_cnt", 32'(cyc_cnt), 32'((c0 + 1) % 256));
        tick();
        chk("nx_t2",  32'(state), 32'd2);

        // 4. Halt at T3 for four edges; NXT during halt is ignored.
        tick();
        c0 = mcnt;
        HLT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            NXT = (i >= 2);
            tick();
            chk("h_state", 32'(state), 32'd4);
            chk("h_idx",   32'(t_idx), 32'd3);
            chk("h_cnt",   32'(cyc_cnt), 32'(c0 % 256));
        end
        HLT = 1'b0;
        NXT = 1'b0;
        tick();
        chk("h_resume", 32'(state), 32'd8);

        // 5. len=1: T1 every edge, counter walks through both wraps.
        len = 3'd1;
        wait_pos(1);
        c0 = mcnt;
        for (int i = 1; i <= 260; i++) begin
            tick();
            chk("l1_start", 32'(cyc_start), 32'd1);
            chk("l1_last",  32'(cyc_last), 32'd1);
            chk("l1_cnt",   32'(cyc_cnt), 32'((c0 + i) % 256));
            chk("l1_cnt2",  32'(cyc_cnt2), 32'((c0 + i) % 4));
        end
        // len=7 clamps to 6.
        len = 3'd7;
        tick();
        chk("l7_t1",   32'(state), 32'd1);
        chk("l7_last", 32'(cyc_last), 32'd0);
        for (int i = 1; i < 6; i++) begin
            tick();
            chk("l7_state", 32'(state), 32'd1 << i);
            chk("l7_lastk", 32'(cyc_last), 32'(i == 5));
        end
        tick();
        chk("l7_wrap", 32'(state), 32'd1);

        // 6. Clear pulse between falling edges has no effect; spanning one clears.
        wait_pos(5);
        CLR_bar = 1'b0;
        #2;
        CLR_bar = 1'b1;
        tick();
        chk("glitch_state", 32'(state), 32'd32);
        CLR_bar = 1'b0;
        tick();
        CLR_bar = 1'b1;
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_idx",   32'(t_idx), 32'd0);
        chk("clr_cnt",   32'(cyc_cnt), 32'd0);
        chk("clr_cnt2",  32'(cyc_cnt2), 32'd0);
        tick();
        chk("clr_t1",    32'(state), 32'd1);
        chk("clr_t1cnt", 32'(cyc_cnt), 32'd0);

        // Randomized phase, checked by the per-cycle compare.
        for (int i = 0; i < 3000; i++) begin
            HLT     = ($urandom_range(0, 7) == 0);
            NXT     = ($urandom_range(0, 7) == 0);
            CLR_bar = ($urandom_range(0, 63) != 0);
            len     = LW'($urandom_range(0, 7));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
